// File: rtl/cici_rate_ctrl.sv
// rtl/cici_rate_ctrl.sv - rate/phase sequencer for a CIC interpolator chain
// Accepts low-rate samples into a one-entry buffer and strobes comb/upsampler/integrator enables per phase.
module cici_rate_ctrl #(
  parameter int gp_ratio_width   = 8,
  parameter int gp_ratio_default = 4,
  parameter int gp_latency       = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_an,
  input  logic                      i_ena,
  input  logic                      i_cfg_wr,
  input  logic [gp_ratio_width-1:0] i_ratio,
  input  logic                      i_stop,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_comb_ena,
  output logic                      o_load,
  output logic                      o_zero_fill,
  output logic                      o_interp_ena,
  output logic [gp_ratio_width-1:0] o_phase,
  output logic                      o_out_valid,
  output logic                      o_underrun,
  output logic                      o_busy
);

  localparam int LW = $clog2(gp_latency + 1);
  localparam logic [gp_ratio_width-1:0] c_one  = gp_ratio_width'(1);
  localparam logic [gp_ratio_width-1:0] c_rdef = gp_ratio_width'(gp_ratio_default);
  localparam logic [LW-1:0]             c_lat  = LW'(gp_latency);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t                    r_state;
  logic [gp_ratio_width-1:0] r_phase;
  logic [gp_ratio_width-1:0] r_ratio;
  logic [gp_ratio_width-1:0] r_shadow;
  logic                      r_buf_full;
  logic                      r_comb;
  logic                      r_zero;
  logic                      r_under;
  logic                      r_interp;
  logic                      r_out_valid;
  logic [LW-1:0]             r_wcnt;

  logic                      w_accept;
  logic                      w_wrap;
  logic [LW-1:0]             w_wcnt_inc;
  logic [gp_ratio_width-1:0] w_ratio_in;

  assign w_accept   = i_ena & i_valid & ~r_buf_full;
  assign w_wrap     = (r_phase >= (r_ratio - c_one));
  assign w_wcnt_inc = (r_wcnt == c_lat) ? r_wcnt : r_wcnt + LW'(1);
  assign w_ratio_in = (i_ratio == '0) ? c_one : i_ratio;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_ratio     <= c_rdef;
      r_shadow    <= c_rdef;
      r_buf_full  <= 1'b0;
      r_comb      <= 1'b0;
      r_zero      <= 1'b0;
      r_under     <= 1'b0;
      r_interp    <= 1'b0;
      r_out_valid <= 1'b0;
      r_wcnt      <= '0;
    end else if (i_ena) begin
      r_comb   <= 1'b0;
      r_zero   <= 1'b0;
      r_under  <= 1'b0;
      r_interp <= 1'b0;
      if (i_cfg_wr) r_shadow <= w_ratio_in;
      case (r_state)
        S_IDLE: begin
          if (r_buf_full) begin
            r_state     <= S_RUN;
            r_phase     <= '0;
            r_ratio     <= r_shadow;
            r_buf_full  <= 1'b0;
            r_comb      <= 1'b0 | 1'b1;
            r_interp    <= 1'b1;
            r_wcnt      <= '0;
            r_out_valid <= 1'b0;
          end else begin
            r_buf_full <= w_accept;
          end
        end
        default: begin
          r_wcnt      <= w_wcnt_inc;
          r_out_valid <= (w_wcnt_inc == c_lat);
          if (!w_wrap) begin
            r_phase    <= r_phase + c_one;
            r_interp   <= 1'b1;
            r_buf_full <= r_buf_full | w_accept;
            if (i_stop) r_state <= S_STOP;
          end else begin
            r_phase <= '0;
            r_ratio <= r_shadow;
            if (r_state == S_STOP) begin
              // terminating wrap: no comb strobe, buffered sample survives for the next start
              r_state     <= S_IDLE;
              r_wcnt      <= '0;
              r_out_valid <= 1'b0;
              r_buf_full  <= r_buf_full | w_accept;
            end else begin
              r_comb     <= 1'b1;
              r_interp   <= 1'b1;
              r_zero     <= ~r_buf_full;
              r_under    <= ~r_buf_full;
              r_buf_full <= w_accept;
              if (i_stop) r_state <= S_STOP;
            end
          end
        end
      endcase
    end
  end

  // Strobes are gated so a disabled cycle looks like no cycle at all.
  assign o_ready      = ~r_buf_full;
  assign o_comb_ena   = r_comb & i_ena;
  assign o_load       = r_comb & i_ena;
  assign o_zero_fill  = r_zero;
  assign o_interp_ena = r_interp & i_ena;
  assign o_underrun   = r_under & i_ena;
  assign o_phase      = r_phase;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cici_rate_ctrl.sv
// tb/tb_cici_rate_ctrl.sv - self-checking bench for cici_rate_ctrl
// Directed scenarios with constant expectations plus randomized traffic against a cycle reference model.
module tb_cici_rate_ctrl;
  localparam int W = 8;
  localparam int L = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_an = 1'b0;
  logic         i_ena = 1'b0;
  logic         i_cfg_wr = 1'b0;
  logic [W-1:0] i_ratio = '0;
  logic         i_stop = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready, o_comb_ena, o_load, o_zero_fill, o_interp_ena;
  logic [W-1:0] o_phase;
  logic         o_out_valid, o_underrun, o_busy;

  int n_checks = 0;
  int n_fail = 0;

  int m_mode, m_phase, m_r, m_sh, m_full, m_cnt, m_comb, m_zf, m_und, m_int;
  int ob_phase, ob_comb, ob_busy, ob_und, ob_zf, ob_int, ob_ov;

  always #5 i_clk = ~i_clk;

  cici_rate_ctrl #(.gp_ratio_width(W), .gp_ratio_default(4), .gp_latency(L)) u_dut (
    .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_cfg_wr(i_cfg_wr),
    .i_ratio(i_ratio), .i_stop(i_stop), .i_valid(i_valid), .o_ready(o_ready),
    .o_comb_ena(o_comb_ena), .o_load(o_load), .o_zero_fill(o_zero_fill),
    .o_interp_ena(o_interp_ena), .o_phase(o_phase), .o_out_valid(o_out_valid),
    .o_underrun(o_underrun), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_r = 4; m_sh = 4; m_full = 0; m_cnt = 0;
    m_comb = 0; m_zf = 0; m_und = 0; m_int = 0;
  endtask

  // mode: 0 idle, 1 run, 2 stopping; m_* outputs describe the cycle after the edge
  task automatic model_edge(input int ena, input int valid, input int cfg, input int stop, input int ratio);
    int acc, old_sh;
    if (ena == 0) return;
    acc = (valid != 0 && m_full == 0) ? 1 : 0;
    old_sh = m_sh;
    if (cfg != 0) m_sh = (ratio == 0) ? 1 : ratio;
    m_comb = 0; m_zf = 0; m_und = 0; m_int = 0;
    if (m_mode == 0) begin
      if (m_full != 0) begin
        m_mode = 1; m_phase = 0; m_r = old_sh; m_full = 0; m_comb = 1; m_int = 1; m_cnt = 0;
      end else m_full = acc;
    end else begin
      m_cnt = (m_cnt < L) ? m_cnt + 1 : L;
      if (m_phase == m_r - 1) begin
        m_r = old_sh; m_phase = 0;
        if (m_mode == 2) begin
          m_mode = 0; m_cnt = 0; m_full = m_full | acc;
        end else begin
          m_comb = 1; m_int = 1; m_zf = 1 - m_full; m_und = 1 - m_full; m_full = acc;
          if (stop != 0) m_mode = 2;
        end
      end else begin
        m_phase = m_phase + 1; m_int = 1; m_full = m_full | acc;
        if (stop != 0) m_mode = 2;
      end
    end
  endtask

  task automatic step(input int ena, input int valid, input int cfg, input int stop, input int ratio);
    i_ena = ena[0]; i_valid = valid[0]; i_cfg_wr = cfg[0]; i_stop = stop[0]; i_ratio = W'(ratio);
    @(negedge i_clk);
    ob_phase = int'(o_phase); ob_comb = int'(o_comb_ena); ob_busy = int'(o_busy);
    ob_und = int'(o_underrun); ob_zf = int'(o_zero_fill); ob_int = int'(o_interp_ena);
    ob_ov = int'(o_out_valid);
    chk("ready", int'(o_ready), 1 - m_full);
    chk("comb_ena", ob_comb, m_comb & ena);
    chk("load", int'(o_load), m_comb & ena);
    chk("zero_fill", ob_zf, m_zf);
    chk("interp_ena", ob_int, m_int & ena);
    chk("underrun", ob_und, m_und & ena);
    chk("phase", ob_phase, m_phase);
    chk("out_valid", ob_ov, (m_mode != 0 && m_cnt == L) ? 1 : 0);
    chk("busy", ob_busy, (m_mode != 0) ? 1 : 0);
    @(posedge i_clk);
    model_edge(ena, valid, cfg, stop, ratio);
    #1;
  endtask

  initial begin
    int saw;
    int exp_ph[6];
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_ov", int'(o_out_valid), 0);
    i_rst_an = 1'b1;

    // R=4 with samples always available: strobes at t+2, t+6, t+10, valid after 8 interp cycles
    for (int s = 0; s < 14; s++) begin
      step(1, 1, 0, 0, 0);
      if (s < 2) chk("b_idle_busy", ob_busy, 0);
      else begin
        chk("b_phase", ob_phase, (s - 2) % 4);
        chk("b_comb", ob_comb, ((s - 2) % 4 == 0) ? 1 : 0);
        chk("b_no_underrun", ob_und, 0);
        chk("b_ov", ob_ov, (s - 2 >= 8) ? 1 : 0);
      end
    end

    saw = 0;
    repeat (10) begin
      step(1, 0, 0, 0, 0);
      if (ob_und == 1 && ob_zf == 1 && ob_comb == 1) saw = 1;
    end
    chk("underrun_seen", saw, 1);

    for (int n = 0; n < 8 && m_phase != 1; n++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 3);
    chk("cfg_at_phase1", ob_phase, 1);
    exp_ph = '{2, 3, 0, 1, 2, 0};
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0);
      chk("ratio_change_phase", ob_phase, exp_ph[i]);
    end

    step(1, 0, 1, 0, 4);
    for (int n = 0; n < 16 && !(m_r == 4 && m_phase == 2 && m_mode == 1); n++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("stop_at_phase2", ob_phase, 2);
    chk("ov_before_stop", ob_ov, 1);
    step(1, 0, 0, 0, 0);
    chk("stop_phase3", ob_phase, 3);
    chk("stop_busy3", ob_busy, 1);
    step(1, 0, 0, 0, 0);
    chk("stop_end_phase", ob_phase, 0);
    chk("stop_end_busy", ob_busy, 0);
    chk("stop_end_ov", ob_ov, 0);
    chk("stop_end_comb", ob_comb, 0);

    step(1, 1, 0, 0, 0);
    for (int n = 0; n < 10 && !(m_mode == 1 && m_phase == 1); n++) step(1, 0, 0, 0, 0);
    repeat (5) begin
      step(0, 1, 0, 0, 0);
      chk("frozen_phase", ob_phase, 1);
      chk("frozen_interp", ob_int, 0);
    end
    step(1, 0, 0, 0, 0);
    chk("resume_phase", ob_phase, 1);
    chk("resume_interp", ob_int, 1);

    step(1, 1, 1, 0, 0);
    repeat (8) step(1, 1, 0, 0, 0);
    repeat (4) begin
      step(1, 1, 0, 0, 0);
      chk("r1_comb", ob_comb, 1);
      chk("r1_phase", ob_phase, 0);
    end

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) != 0) ? 1 : 0, ($urandom_range(0, 4) < 3) ? 1 : 0,
           ($urandom_range(0, 31) == 0) ? 1 : 0, ($urandom_range(0, 63) == 0) ? 1 : 0,
           int'($urandom_range(0, 6)));
    end

    for (int n = 0; n < 20 && m_mode == 0; n++) step(1, 1, 0, 0, 0);
    chk("pre_reset_busy", int'(o_busy), 1);
    #3;
    i_rst_an = 1'b0;
    #1;
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_phase", int'(o_phase), 0);
    chk("arst_ready", int'(o_ready), 1);
    chk("arst_comb", int'(o_comb_ena), 0);
    chk("arst_ov", int'(o_out_valid), 0);
    chk("arst_interp", int'(o_interp_ena), 0);
    model_reset();
    @(negedge i_clk);
    i_rst_an = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (8) step(1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
